// File: rtl/dmem_unit.sv
// Data-memory stage: data RAM on the CPU DA/DD/RW port, host preload
// port and a three-register I/O window (result, cycle count, status).
module dmem_unit #(
  parameter int unsigned    AW      = 7,
  parameter int unsigned    DW      = 16,
  parameter logic [DW-1:0]  IO_BASE = 16'hFF00
) (
  input  logic          CK,
  input  logic          RST,
  input  logic [DW-1:0] DA,
  inout  wire  [DW-1:0] DD,
  input  logic          RW,
  input  logic          LD_EN,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [DW-1:0] LD_DATA,
  output logic          DONE,
  output logic [DW-1:0] RESULT,
  output logic          ERR
);

  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_result;
  logic [DW-1:0] r_cyc;
  logic          r_done;
  logic          r_err;

  logic [DW-1:0] w_io_off;
  logic [AW-1:0] w_ram_addr;
  logic          w_is_ram;
  logic          w_is_io;
  logic          w_unmapped;
  logic          w_io_res;
  logic          w_cpu_we;
  logic [DW-1:0] w_status;
  logic [DW-1:0] w_io_val;
  logic [DW-1:0] w_rd_val;

  assign w_io_off   = DA - IO_BASE;
  assign w_ram_addr = DA[AW-1:0];
  assign w_is_ram   = ~|DA[DW-1:AW];
  assign w_is_io    = (DA >= IO_BASE) && (w_io_off <= DW'(2));
  assign w_unmapped = !w_is_ram && !w_is_io;
  assign w_io_res   = w_is_io && (w_io_off == '0);
  assign w_status   = {{(DW-3){1'b0}}, r_err, r_done, 1'b1};

  // Preload owns the slot when both target the same word.
  assign w_cpu_we = !RST && !RW && w_is_ram &&
                    !(LD_EN && (LD_ADDR == w_ram_addr));

  always_comb begin
    w_io_val = '0;
    unique case (w_io_off[1:0])
      2'd0:    w_io_val = r_result;
      2'd1:    w_io_val = r_cyc;
      2'd2:    w_io_val = w_status;
      default: w_io_val = '0;
    endcase
  end

  always_comb begin
    w_rd_val = '0;
    unique case (1'b1)
      w_is_ram:   w_rd_val = r_mem[w_ram_addr];
      w_is_io:    w_rd_val = w_io_val;
      w_unmapped: w_rd_val = '0;
      default:    w_rd_val = '0;
    endcase
  end

  // RAM is never cleared so the host may preload under reset.
  always_ff @(negedge CK) begin
    if (w_cpu_we)
      r_mem[w_ram_addr] <= DD;
    if (LD_EN)
      r_mem[LD_ADDR] <= LD_DATA;
  end

  always_ff @(negedge CK) begin
    if (RST) begin
      r_rdata  <= '0;
      r_result <= '0;
      r_cyc    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cyc <= r_cyc + 1'b1;
      if (RW)
        r_rdata <= w_rd_val;
      if (w_unmapped)
        r_err <= 1'b1;
      if (!RW && w_io_res) begin
        r_result <= DD;
        r_done   <= 1'b1;
      end
    end
  end

  assign DD     = RW ? r_rdata : {DW{1'bz}};
  assign DONE   = r_done;
  assign RESULT = r_result;
  assign ERR    = r_err;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: loads, stores, I/O window,
// preload collisions and reset behaviour.
module tb_dmem_unit;

  logic        CK;
  logic        RST;
  logic [15:0] DA;
  wire  [15:0] DD;
  logic        RW;
  logic        LD_EN;
  logic [6:0]  LD_ADDR;
  logic [15:0] LD_DATA;
  logic        DONE;
  logic [15:0] RESULT;
  logic        ERR;
  logic [15:0] tb_dd;

  int n_tests = 0;
  int n_fail  = 0;

  assign DD = RW ? 16'hzzzz : tb_dd;

  dmem_unit #(.AW(7), .DW(16), .IO_BASE(16'hFF00)) dut (
    .CK(CK), .RST(RST), .DA(DA), .DD(DD), .RW(RW),
    .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
    .DONE(DONE), .RESULT(RESULT), .ERR(ERR)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one bus cycle on the rising edge; return just after the falling edge.
  task automatic tick(input logic rst, input logic rw,
                      input logic [15:0] da, input logic [15:0] dd,
                      input logic le, input logic [6:0] la,
                      input logic [15:0] ldat);
    @(posedge CK);
    RST = rst; RW = rw; DA = da; tb_dd = dd;
    LD_EN = le; LD_ADDR = la; LD_DATA = ldat;
    @(negedge CK);
    #1;
  endtask

  task automatic rd(input logic [15:0] da);
    tick(1'b0, 1'b1, da, 16'h0, 1'b0, 7'd0, 16'h0);
  endtask

  task automatic wr(input logic [15:0] da, input logic [15:0] dd);
    tick(1'b0, 1'b0, da, dd, 1'b0, 7'd0, 16'h0);
  endtask

  initial begin
    RST = 1'b1; RW = 1'b1; DA = '0; tb_dd = '0;
    LD_EN = 1'b0; LD_ADDR = '0; LD_DATA = '0;

    // 1: preload under reset, then read
    tick(1'b1, 1'b1, 16'h0, 16'h0, 1'b1, 7'd0, 16'd5);
    chk("rst_dd", DD, 16'h0);
    chk("rst_done", {15'b0, DONE}, 16'h0);
    chk("rst_err", {15'b0, ERR}, 16'h0);
    chk("rst_result", RESULT, 16'h0);
    tick(1'b1, 1'b1, 16'h0, 16'h0, 1'b1, 7'd1, 16'd50);
    tick(1'b1, 1'b1, 16'h0, 16'h0, 1'b1, 7'd5, 16'h0055);
    rd(16'h0001);
    chk("t1_rd1", DD, 16'd50);
    chk("t1_done", {15'b0, DONE}, 16'h0);
    chk("t1_err", {15'b0, ERR}, 16'h0);
    rd(16'h0000);
    chk("t1_rd0", DD, 16'd5);

    // 2: store then load
    wr(16'h0000, 16'd4);
    rd(16'h0000);
    chk("t2_rd0", DD, 16'd4);
    rd(16'h0001);
    chk("t2_rd1", DD, 16'd50);

    // 3: result register and status
    wr(16'hFF00, 16'h0104);
    chk("t3_result", RESULT, 16'h0104);
    chk("t3_done", {15'b0, DONE}, 16'h1);
    rd(16'hFF02);
    chk("t3_status", DD, 16'h0003);
    rd(16'hFF00);
    chk("t3_rd_res", DD, 16'h0104);
    wr(16'hFF01, 16'hBEEF);
    chk("t3_ro_result", RESULT, 16'h0104);

    // 4: unmapped accesses
    rd(16'h0200);
    chk("t4_unm_dd", DD, 16'h0);
    chk("t4_err", {15'b0, ERR}, 16'h1);
    wr(16'h0300, 16'hAAAA);
    chk("t4_err_stay", {15'b0, ERR}, 16'h1);
    rd(16'h0000);
    chk("t4_ram0", DD, 16'd4);
    rd(16'hFF03);
    chk("t4_io3", DD, 16'h0);
    rd(16'hFF02);
    chk("t4_status", DD, 16'h0007);

    // 5: preload collisions
    tick(1'b0, 1'b0, 16'h0002, 16'd7, 1'b1, 7'd2, 16'd9);
    rd(16'h0002);
    chk("t5_ld_wins", DD, 16'd9);
    tick(1'b0, 1'b0, 16'h0004, 16'h0044, 1'b1, 7'd6, 16'h0066);
    rd(16'h0004);
    chk("t5_cpu_diff", DD, 16'h0044);
    rd(16'h0006);
    chk("t5_ld_diff", DD, 16'h0066);
    tick(1'b0, 1'b1, 16'h0000, 16'h0, 1'b1, 7'd3, 16'h0033);
    tick(1'b0, 1'b1, 16'h0003, 16'h0, 1'b1, 7'd3, 16'h0099);
    chk("t5_rbw_old", DD, 16'h0033);
    rd(16'h0003);
    chk("t5_rbw_new", DD, 16'h0099);

    // 6: reset mid-operation
    for (int i = 0; i < 100; i++) rd(16'h0001);
    chk("t6_run_rd", DD, 16'd50);
    tick(1'b1, 1'b0, 16'h0005, 16'h0001, 1'b0, 7'd0, 16'h0);
    chk("t6_done", {15'b0, DONE}, 16'h0);
    chk("t6_err", {15'b0, ERR}, 16'h0);
    chk("t6_result", RESULT, 16'h0);
    rd(16'hFF01);
    chk("t6_cyc0", DD, 16'h0000);
    rd(16'hFF01);
    chk("t6_cyc1", DD, 16'h0001);
    rd(16'h0005);
    chk("t6_ram5", DD, 16'h0055);
    tick(1'b1, 1'b1, 16'h0200, 16'h0, 1'b0, 7'd0, 16'h0);
    chk("t6_rst_dd", DD, 16'h0);
    chk("t6_rst_noerr", {15'b0, ERR}, 16'h0);
    tick(1'b1, 1'b0, 16'hFF00, 16'h1234, 1'b0, 7'd0, 16'h0);
    chk("t6_rst_nodone", {15'b0, DONE}, 16'h0);
    chk("t6_rst_nores", RESULT, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
